instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end fetch stage feeding the decoder. Holds the architectural fetch PC and issues one-word instruction reads to the memory/icache port. Applies static next-PC prediction (JAL taken, backward branch taken) and buffers fetched words in a small FIFO. The decoder drains the FIFO through a valid/ready handshake. On a ROB `clear`, all in-flight work is flushed and fetch restarts at `redirect_pc`.

## Interface
- `QUEUE_DEPTH`, default 4: fetch FIFO entries; must be a power of 2 and at least 2.
- `QUEUE_WIDTH`, default 2: log2(`QUEUE_DEPTH`).
- `clk_in` in 1: single clock; all state updates on the rising edge.
- `rst_in` in 1: reset; synchronous, active-low.
- `rdy_in` in 1: global enable. When 0, every register holds.
- `clear` in 1: flush from ROB.
- `redirect_pc` in 32: restart PC, sampled when `clear`=1.
- `mem_req` out 1: one-cycle read request pulse.
- `mem_addr` out 32: request address, valid while `mem_req`=1.
- `mem_valid` in 1: one-cycle response strobe, exactly one per request, latency ≥1 cycle.
- `mem_data` in 32: instruction word, valid with `mem_valid`.
- `dec_valid` out 1: FIFO head valid.
- `dec_ready` in 1: decoder accepts the head this cycle.
- `dec_pc` out 32: PC of the head entry.
- `dec_instr` out 32: instruction word of the head entry.
- `dec_pred_taken` out 1: prediction recorded for the head entry.

## Operation
- **Reset** (`rst_in`=0 at edge):
  - pc=0, state=IDLE, FIFO empty.
  - Outputs: `mem_req`=0, `mem_addr`=0, `dec_valid`=0, `dec_pc`=0, `dec_instr`=0, `dec_pred_taken`=0.
- **FSM states:** IDLE, WAIT, DISCARD.
  - IDLE → WAIT when count < `QUEUE_DEPTH` and `clear`=0. The same edge registers `mem_req`=1 and `mem_addr`=pc.
  - WAIT, `mem_valid`=1: push {pc, `mem_data`, pred} into the FIFO, pc ← next_pc, go to IDLE.
  - DISCARD, `mem_valid`=1: drop the response, go to IDLE.
- **Single outstanding request.** Entering WAIT requires FIFO space, and no other pushes exist, so a push never meets a full FIFO.
- **next_pc** (opcode = instr[6:0]):
  - 7'b1101111 (JAL): pc + sext({i[31],i[19:12],i[20],i[30:21],0}); pred=1.
  - 7'b1100011 with i[31]=1 (backward branch): pc + sext({i[31],i[7],i[30:25],i[11:8],0}); pred=1.
  - Otherwise: pc+4; pred=0. JALR is predicted pc+4.
  - All additions are 32-bit modulo 2^32; wrap from 0xFFFFFFFC to 0 is legal.
- **Dequeue:** `dec_valid` = FIFO not empty, and `dec_*` reflect the head entry. The head is popped when `dec_valid`&`dec_ready`. Push and pop in the same cycle are both performed; count is unchanged.
- **Clear** has the highest priority and overrides everything else that cycle:
  - FIFO emptied; any pop that cycle is ignored.
  - pc ← `redirect_pc`.
  - State: WAIT → DISCARD; IDLE or DISCARD → IDLE.
  - If `mem_valid` arrives in the same cycle as `clear`, the response is dropped and the state goes to IDLE, not DISCARD.
  - No request is issued in the clear cycle.
- **rdy_in=0:** full hold, including pc, FIFO, state and output registers. The memory side is also gated by `rdy_in`, so no response is lost.

## Timing
- Request-to-push: `mem_valid` at edge N places the entry in the FIFO. `dec_valid`=1 after edge N.
- Back-to-back fetch: a push at edge N returns the FSM to IDLE; the next `mem_req` is registered at edge N+1. Minimum 2 cycles per fetched word plus memory latency.
- `clear` at edge N: `dec_valid`=0 after N. The first request to `redirect_pc` is registered at N+1 if the FSM was IDLE, otherwise after the discarded response returns.
- Zero-latency pass-through from `mem_data` to `dec_*` is forbidden; the FIFO always registers.

## Structure
- Shared package holds:
  - Opcode constants `OPC_JAL`=7'b1101111 and `OPC_BRANCH`=7'b1100011, shared with the decoder.
  - FSM state encoding: IDLE, WAIT, DISCARD.
  - The 65-bit FIFO entry layout {pred, pc, instr}.
- One sub-module: `fetch_queue`.
  - Parameterised circular FIFO with head/tail pointers of `QUEUE_WIDTH` bits and a `QUEUE_WIDTH`+1-bit count.
  - Ports: push, pop, flush, full, empty, head data.
- Next-PC prediction logic stays in the top level.

## Test plan
- **Reset then sequential fetch:** memory returns 0x00000013 (NOP) with latency 2, decoder always ready → `mem_addr` sequence 0x0, 0x4, 0x8; `dec_pc` follows the same sequence; `dec_pred_taken`=0.
- **JAL prediction:** word 0x0080006F (jal x0,+8) at pc 0x10 → next `mem_addr`=0x18; `dec_pred_taken`=1.
- **Backward branch:** word 0xFE000EE3 (beq x0,x0,-4) at pc 0x20 → next `mem_addr`=0x1C; pred=1.
  - Forward branch 0x00000463 (beq +8) → next `mem_addr`=0x24; pred=0.
- **FIFO full:** hold `dec_ready`=0 → exactly 4 requests issued, then `mem_req` stays 0. Release `dec_ready` for one cycle → exactly one further request.
- **Clear in WAIT:** `clear` with `redirect_pc`=0x100 while a request is outstanding → the returning word is not enqueued, `dec_valid`=0, next `mem_addr`=0x100.
  - Repeat with `clear` and `mem_valid` in the same cycle → next `mem_addr`=0x100 the following cycle.
- **rdy_in low mid-WAIT for 3 cycles** → pc, FIFO count and `dec_*` outputs are unchanged; after release, the fetch completes normally.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: RISC-V opcode constants, the fetch FSM
// state encoding and the 65-bit fetch-queue entry layout {pred, pc, instr}.
package instruction_fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic            pred;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched words between the fetch FSM and the decoder.
// Ports: clk_in/rst_in (sync, active-low), en_in (global hold when 0),
//        push/push_data, pop, flush (empties the queue, wins over push/pop),
//        full, empty, head_data (all-zero while empty).
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned QUEUE_WIDTH = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         en_in,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head_data
);

   logic [QUEUE_WIDTH-1:0] head_q, head_d;
   logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
   logic [QUEUE_WIDTH:0]   count_q, count_d;
   fetch_entry_t           mem_q [QUEUE_DEPTH];
   fetch_entry_t           mem_d [QUEUE_DEPTH];
   logic                   do_push;
   logic                   do_pop;

   assign full      = (count_q == (QUEUE_WIDTH+1)'(QUEUE_DEPTH));
   assign empty     = (count_q == '0);
   // Zeroed head keeps decoder outputs clean after reset and flush
   assign head_data = empty ? '0 : mem_q[head_q];

   // Pointer/count update; pointers wrap naturally since depth is a power of 2
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_d   = mem_q;
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + QUEUE_WIDTH'(1);
         end
         if (do_pop) begin
            head_d = head_q + QUEUE_WIDTH'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (QUEUE_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (QUEUE_WIDTH+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else if (en_in) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one outstanding instruction read at a
// time, statically predicts the next PC (JAL and backward branches taken) and
// queues fetched words for the decoder.
// Ports: clk_in, rst_in (sync, active-low), rdy_in (global hold),
//        clear/redirect_pc (ROB flush), mem_req/mem_addr (read request),
//        mem_valid/mem_data (read response),
//        dec_valid/dec_ready/dec_pc/dec_instr/dec_pred_taken (decoder side).
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned QUEUE_WIDTH = 2
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            clear,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_valid,
   input  logic [XLEN-1:0] mem_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_instr,
   output logic            dec_pred_taken
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            mem_req_q, mem_req_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;

   logic [XLEN-1:0] jal_imm;
   logic [XLEN-1:0] br_imm;
   logic [XLEN-1:0] next_pc_c;
   logic            pred_c;

   logic            q_push;
   logic            q_pop;
   logic            q_full;
   logic            q_empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    q_head;

   // Static next-PC prediction from the returning word
   always_comb begin
      jal_imm   = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                   mem_data[20], mem_data[30:21], 1'b0};
      br_imm    = {{19{mem_data[31]}}, mem_data[31], mem_data[7],
                   mem_data[30:25], mem_data[11:8], 1'b0};
      pred_c    = 1'b0;
      next_pc_c = pc_q + XLEN'(4);
      if (mem_data[6:0] == OPC_JAL) begin
         pred_c    = 1'b1;
         next_pc_c = pc_q + jal_imm;
      end else if (mem_data[6:0] == OPC_BRANCH && mem_data[31]) begin
         pred_c    = 1'b1;
         next_pc_c = pc_q + br_imm;
      end
   end

   // Fetch FSM; clear overrides every other transition
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      mem_req_d        = 1'b0;
      mem_addr_d       = mem_addr_q;
      q_push           = 1'b0;
      push_entry.pred  = pred_c;
      push_entry.pc    = pc_q;
      push_entry.instr = mem_data;
      if (clear) begin
         pc_d = redirect_pc;
         // A response arriving with the clear is dropped right here
         state_d = (state_q == ST_WAIT && !mem_valid) ? ST_DISCARD : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!q_full) begin
                  state_d    = ST_WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q;
               end
            end
            ST_WAIT: begin
               if (mem_valid) begin
                  q_push  = 1'b1;
                  pc_d    = next_pc_c;
                  state_d = ST_IDLE;
               end
            end
            ST_DISCARD: begin
               if (mem_valid) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   assign q_pop = dec_ready && !q_empty;

   fetch_queue #(
      .QUEUE_DEPTH (QUEUE_DEPTH),
      .QUEUE_WIDTH (QUEUE_WIDTH)
   ) u_queue (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en_in     (rdy_in),
      .push      (q_push),
      .push_data (push_entry),
      .pop       (q_pop),
      .flush     (clear),
      .full      (q_full),
      .empty     (q_empty),
      .head_data (q_head)
   );

   assign mem_req        = mem_req_q;
   assign mem_addr       = mem_addr_q;
   assign dec_valid      = !q_empty;
   assign dec_pc         = q_head.pc;
   assign dec_instr      = q_head.instr;
   assign dec_pred_taken = q_head.pred;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory responder and a queue-based model of
// the fetch stream (expected PCs, queued words, discarded responses).
module tb_instruction_fetch;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear, mem_valid, dec_ready;
   logic [31:0] redirect_pc, mem_data;
   logic        mem_req, dec_valid, dec_pred_taken;
   logic [31:0] mem_addr, dec_pc, dec_instr;

   always #5 clk_in = ~clk_in;

   instruction_fetch #(.QUEUE_DEPTH(4), .QUEUE_WIDTH(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_data(mem_data), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr),
      .dec_pred_taken(dec_pred_taken)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; logic pred; } ent_t;

   ent_t        mq[$];
   ent_t        obs_dec[$];
   logic [31:0] obs_addr[$];
   logic [31:0] prog [logic [31:0]];
   logic [31:0] mpc, pend_addr;
   bit          pend, discard, rand_mode;
   int          lat_cnt, mem_lat;
   int          total = 0, bad = 0;

   function automatic bit pred_taken(input logic [31:0] i);
      return (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100011 && i[31]);
   endfunction

   // Target from plain signed arithmetic on the immediate fields
   function automatic logic [31:0] pred_target(input logic [31:0] pc, input logic [31:0] i);
      int off;
      if (i[6:0] == 7'b1101111)
         off = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
               + int'(i[30:21]) * 2;
      else if (i[6:0] == 7'b1100011 && i[31])
         off = -4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      else
         off = 4;
      return pc + 32'(off);
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0:       w = 32'h0000_0013;
         1:       w[6:0] = 7'b1101111;
         2:       w[6:0] = 7'b1100011;
         default: w[6:0] = 7'b1100111;
      endcase
      return w;
   endfunction

   // One clock: memory responds, model advances, return at the falling edge
   task automatic cycle();
      bit   deliver;
      ent_t e;
      deliver   = 0;
      mem_valid = 1'b0;
      mem_data  = '0;
      if (!rst_in) begin
         pend = 0; discard = 0; mq.delete(); mpc = '0;
      end else if (rdy_in) begin
         if (pend) begin
            if (lat_cnt <= 1) begin
               deliver = 1; pend = 0; mem_valid = 1'b1; mem_data = prog[pend_addr];
            end else lat_cnt--;
         end
         if (mem_req) begin
            pend = 1; pend_addr = mem_addr; lat_cnt = mem_lat;
            if (!prog.exists(mem_addr)) prog[mem_addr] = rand_mode ? gen_instr() : 32'h13;
         end
         if (clear) begin
            mq.delete(); mpc = redirect_pc; discard = pend;
         end else begin
            if (dec_ready && mq.size() > 0) void'(mq.pop_front());
            if (deliver) begin
               if (discard) discard = 0;
               else begin
                  e.pc = mpc; e.instr = mem_data; e.pred = pred_taken(mem_data);
                  mq.push_back(e);
                  mpc = pred_target(mpc, mem_data);
               end
            end
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic restart(input logic [31:0] pc);
      rst_in = 1'b0; clear = 1'b0; rdy_in = 1'b1; dec_ready = 1'b0;
      cycle(); cycle();
      rst_in = 1'b1; clear = 1'b1; redirect_pc = pc;
      cycle();
      clear = 1'b0;
      obs_addr.delete(); obs_dec.delete();
   endtask

   task automatic run_collect(input int want, input int budget, output bit timed_out);
      ent_t e;
      timed_out = 1;
      for (int c = 0; c < budget; c++) begin
         cycle();
         if (mem_req) obs_addr.push_back(mem_addr);
         if (dec_valid && dec_ready) begin
            e.pc = dec_pc; e.instr = dec_instr; e.pred = dec_pred_taken;
            obs_dec.push_back(e);
         end
         if (obs_addr.size() >= want) begin timed_out = 0; break; end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0;
      redirect_pc = '0; mem_lat = 2; rand_mode = 0; pend = 0; discard = 0;
      cycle(); cycle();
      total++;
      if ({mem_req, dec_valid, dec_pred_taken} !== 3'b000 || mem_addr !== 32'h0 ||
          dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
         bad++;
         $display("FAIL reset: req=%b addr=%h valid=%b pc=%h instr=%h pred=%b, want all zero",
                  mem_req, mem_addr, dec_valid, dec_pc, dec_instr, dec_pred_taken);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] seq [3];
      bit to;
      seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h8;
      prog.delete(); rand_mode = 0; mem_lat = 2;
      rst_in = 1'b0; cycle();
      rst_in = 1'b1; dec_ready = 1'b1;
      obs_addr.delete(); obs_dec.delete();
      run_collect(4, 60, to);
      total++;
      if (to || obs_dec.size() < 3) begin
         bad++; $display("FAIL seq_timeout: reqs=%0d decs=%0d want >=3", obs_addr.size(), obs_dec.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_addr[k] !== seq[k]) begin
               bad++; $display("FAIL seq_addr%0d: got %h want %h", k, obs_addr[k], seq[k]);
            end
            total++;
            if (obs_dec[k].pc !== seq[k] || obs_dec[k].pred !== 1'b0 || obs_dec[k].instr !== 32'h13) begin
               bad++;
               $display("FAIL seq_dec%0d: got pc=%h pred=%b instr=%h want pc=%h pred=0 instr=00000013",
                        k, obs_dec[k].pc, obs_dec[k].pred, obs_dec[k].instr, seq[k]);
            end
         end
      end
   endtask

   // One word at start_pc: check the following request address and the prediction bit
   task automatic test_predict(input string name, input logic [31:0] start_pc, input logic [31:0] word,
                               input logic [31:0] want_next, input logic want_pred);
      bit to;
      prog.delete(); rand_mode = 0; mem_lat = 2;
      prog[start_pc] = word;
      restart(start_pc);
      dec_ready = 1'b1;
      run_collect(2, 60, to);
      total++;
      if (to || obs_dec.size() < 1) begin
         bad++; $display("FAIL %s_timeout: reqs=%0d decs=%0d want 2/1", name, obs_addr.size(), obs_dec.size());
      end else begin
         total++;
         if (obs_addr[0] !== start_pc || obs_addr[1] !== want_next) begin
            bad++; $display("FAIL %s_addr: got %h,%h want %h,%h", name, obs_addr[0], obs_addr[1], start_pc, want_next);
         end
         total++;
         if (obs_dec[0].pred !== want_pred || obs_dec[0].pc !== start_pc || obs_dec[0].instr !== word) begin
            bad++;
            $display("FAIL %s_dec: got pred=%b pc=%h instr=%h want pred=%b pc=%h instr=%h", name,
                     obs_dec[0].pred, obs_dec[0].pc, obs_dec[0].instr, want_pred, start_pc, word);
         end
      end
   endtask

   task automatic test_fifo_full();
      bit to;
      prog.delete(); rand_mode = 0; mem_lat = 2;
      restart(32'h0);
      run_collect(99, 60, to);
      total++;
      if (obs_addr.size() != 4 || (obs_addr.size() == 4 && obs_addr[3] !== 32'hC)) begin
         bad++; $display("FAIL full_reqs: got %0d requests want 4 (last 0000000c)", obs_addr.size());
      end
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
         bad++; $display("FAIL full_head: got valid=%b pc=%h want 1/00000000", dec_valid, dec_pc);
      end
      obs_addr.delete();
      dec_ready = 1'b1;
      run_collect(99, 1, to);
      dec_ready = 1'b0;
      run_collect(99, 40, to);
      total++;
      if (obs_addr.size() != 1 || (obs_addr.size() == 1 && obs_addr[0] !== 32'h10)) begin
         bad++; $display("FAIL full_release: got %0d requests want 1 (00000010)", obs_addr.size());
      end
      total++;
      if (dec_pc !== 32'h4) begin
         bad++; $display("FAIL full_pop: got head pc %h want 00000004", dec_pc);
      end
   endtask

   task automatic test_clear_wait();
      bit seen;
      int c;
      prog.delete(); rand_mode = 0; mem_lat = 3;
      restart(32'h0);
      c = 0;
      while (!(mq.size() == 2 && mem_req) && c < 60) begin cycle(); c++; end
      total++;
      if (c >= 60) begin bad++; $display("FAIL clrw_setup: got timeout want third request"); end
      clear = 1'b1; redirect_pc = 32'h100;
      cycle();
      clear = 1'b0;
      total++;
      if (dec_valid !== 1'b0) begin bad++; $display("FAIL clrw_flush: got valid=%b want 0", dec_valid); end
      seen = 0;
      for (int k = 0; k < 30 && !seen; k++) begin
         cycle();
         if (mem_req) begin
            seen = 1;
            total++;
            if (mem_addr !== 32'h100) begin bad++; $display("FAIL clrw_addr: got %h want 00000100", mem_addr); end
         end else begin
            total++;
            if (dec_valid !== 1'b0) begin bad++; $display("FAIL clrw_drop: got valid=%b want 0", dec_valid); end
         end
      end
      total++;
      if (!seen) begin bad++; $display("FAIL clrw_timeout: got no request want one to 00000100"); end

      // clear landing on the same edge as the response
      restart(32'h0);
      c = 0;
      while (!(pend && lat_cnt == 1) && c < 60) begin cycle(); c++; end
      clear = 1'b1; redirect_pc = 32'h100;
      cycle();
      clear = 1'b0;
      total++;
      if (dec_valid !== 1'b0 || mem_req !== 1'b0) begin
         bad++; $display("FAIL clrv_edge: got valid=%b req=%b want 0/0", dec_valid, mem_req);
      end
      cycle();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         bad++; $display("FAIL clrv_addr: got req=%b addr=%h want 1/00000100", mem_req, mem_addr);
      end
   endtask

   task automatic test_rdy_hold();
      int c;
      bit to;
      prog.delete(); rand_mode = 0; mem_lat = 3;
      prog[32'h0] = 32'h0080006F;
      restart(32'h0);
      c = 0;
      while (!(mq.size() == 1 && mem_req) && c < 60) begin cycle(); c++; end
      rdy_in = 1'b0; dec_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         total++;
         if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== 32'h0080006F ||
             dec_pred_taken !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            bad++;
            $display("FAIL hold%0d: got v=%b pc=%h instr=%h pred=%b req=%b addr=%h want 1/0/0080006f/1/1/8",
                     k, dec_valid, dec_pc, dec_instr, dec_pred_taken, mem_req, mem_addr);
         end
      end
      rdy_in = 1'b1; dec_ready = 1'b0;
      obs_addr.delete();
      run_collect(1, 40, to);
      total++;
      if (to || obs_addr[0] !== 32'hC || dec_pc !== 32'h0 || mq.size() != 2) begin
         bad++; $display("FAIL hold_resume: got timeout=%b head=%h model_size=%0d want 0/0/2", to, dec_pc, mq.size());
      end
   endtask

   task automatic test_random();
      prog.delete(); rand_mode = 1;
      restart($urandom & 32'hFFFF_FFFC);
      for (int c = 0; c < 1500; c++) begin
         rdy_in      = ($urandom_range(0, 7) != 0);
         dec_ready   = $urandom_range(0, 1) != 0;
         mem_lat     = $urandom_range(1, 4);
         clear       = !discard && ($urandom_range(0, 39) == 0);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         cycle();
         clear = 1'b0;
         total++;
         if (dec_valid !== (mq.size() != 0)) begin
            bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, dec_valid, mq.size() != 0);
         end else if (mq.size() != 0) begin
            total++;
            if (dec_pc !== mq[0].pc || dec_instr !== mq[0].instr || dec_pred_taken !== mq[0].pred) begin
               bad++;
               $display("FAIL rnd_head@%0d: got %h/%h/%b want %h/%h/%b", c, dec_pc, dec_instr,
                        dec_pred_taken, mq[0].pc, mq[0].instr, mq[0].pred);
            end
         end
         if (mem_req) begin
            total++;
            if (mem_addr !== mpc || mq.size() >= 4) begin
               bad++; $display("FAIL rnd_req@%0d: got addr=%h size=%0d want %h size<4", c, mem_addr, mq.size(), mpc);
            end
         end
      end
      rdy_in = 1'b1;
   endtask

   initial begin
      mem_valid = 1'b0; mem_data = '0;
      test_reset();
      test_sequential();
      test_predict("jal", 32'h10, 32'h0080006F, 32'h18, 1'b1);
      test_predict("bwd", 32'h20, 32'hFE000EE3, 32'h1C, 1'b1);
      test_predict("fwd", 32'h20, 32'h00000463, 32'h24, 1'b0);
      test_predict("wrap", 32'hFFFFFFFC, 32'h00000013, 32'h0, 1'b0);
      test_fifo_full();
      test_clear_wait();
      test_rdy_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
